// File: rtl/clk_div_pkg.sv
// clk_div_pkg
// Shared definitions for the multi-channel clock divider (clk_div_multi and
// its per-channel core clk_div_ch).
//   CLK_DIV_WIDTH_DEFAULT : default divisor/counter width in bits
//   CLK_DIV_DEF_DIV       : reset divisor, 1 Hz toggle output from 50 MHz
//   clk_div_mode_e        : per-channel output mode (toggle / pulse)
//   ch_idx_width()        : width of a channel-index bus, never below 1 bit
package clk_div_pkg;

  localparam int CLK_DIV_WIDTH_DEFAULT = 32;
  localparam int unsigned CLK_DIV_DEF_DIV = 32'd24999999;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } clk_div_mode_e;

  // A single-channel build still needs a 1-bit index port so that an
  // out-of-range index (1) can be expressed and ignored.
  function automatic int ch_idx_width(input int n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch
// One divider channel: free-running counter, runtime-loadable divisor
// register, wrap compare and the registered toggle / tick outputs.
// Optional macro CLKDIV_SYNC_EN adds the 'sync' phase-alignment input.
// Ports:
//   clk      in   system clock (CCLK)
//   rst      in   synchronous active-high reset
//   en       in   run enable; when low, count and clk_out hold, tick is 0
//   mode     in   MODE_TOGGLE (square wave) or MODE_PULSE (one-cycle tick)
//   div_we   in   divisor write strobe for this channel
//   div_val  in   divisor value written when div_we is high
//   sync     in   (CLKDIV_SYNC_EN only) clears count and outputs
//   clk_out  out  registered square-wave output
//   tick     out  registered one-cycle strobe
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int               WIDTH   = CLK_DIV_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] DEF_DIV = WIDTH'(CLK_DIV_DEF_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  clk_div_mode_e    mode,
  input  logic             div_we,
  input  logic [WIDTH-1:0] div_val,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  output logic             clk_out,
  output logic             tick
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] cnt_nxt;
  logic             clk_nxt;
  logic             tick_nxt;
  logic             wrap;

  // The compare is >= rather than == so that loading a divisor below the
  // current count forces a wrap on the next cycle instead of letting the
  // counter run all the way round 2^WIDTH.
  assign wrap = (cnt >= div);

  // Next-state for counter and outputs. Mode only matters at a wrap, so a
  // mid-count mode change takes effect at the next wrap; a toggle-mode wrap
  // never raises tick and a pulse-mode wrap never moves clk_out.
  always_comb begin
    cnt_nxt  = cnt;
    clk_nxt  = clk_out;
    tick_nxt = 1'b0;
    if (en) begin
      if (wrap) begin
        cnt_nxt = '0;
        if (mode == MODE_TOGGLE) begin
          clk_nxt = ~clk_out;
        end else begin
          tick_nxt = 1'b1;
        end
      end else begin
        cnt_nxt = cnt + WIDTH'(1);
      end
    end
`ifdef CLKDIV_SYNC_EN
    // Alignment overrides counting but not the divisor write below.
    if (sync) begin
      cnt_nxt  = '0;
      clk_nxt  = 1'b0;
      tick_nxt = 1'b0;
    end
`endif
  end

  // State registers. The divisor write is independent of the counter path:
  // this cycle's wrap compare still sees the old divisor, the new one is
  // used from the next cycle on.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      div     <= DEF_DIV;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      clk_out <= clk_nxt;
      tick    <= tick_nxt;
      if (div_we) begin
        div <= div_val;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi
// N_CH independent clock dividers running from the 50 MHz crystal clock.
// Each channel produces either a 50% square wave (toggle mode, period
// 2*(div+1) cycles) or a one-cycle clock-enable tick (pulse mode, period
// div+1 cycles). Divisors are written one channel at a time via load.
// Optional macro CLKDIV_SYNC_EN adds sync_in, which phase-aligns all channels.
// Ports:
//   CCLK      in   50 MHz system clock
//   rst       in   synchronous active-high reset
//   en        in   per-channel run enable
//   mode      in   per-channel mode, 0 = toggle, 1 = pulse
//   load      in   divisor write strobe (one cycle)
//   load_ch   in   channel index for the write; indices >= N_CH are ignored
//   load_val  in   divisor value
//   sync_in   in   (CLKDIV_SYNC_EN only) clear every channel's phase
//   clk_out   out  per-channel registered square-wave outputs
//   tick      out  per-channel registered one-cycle strobes
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int               N_CH    = 4,
  parameter int               WIDTH   = CLK_DIV_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] DEF_DIV = WIDTH'(CLK_DIV_DEF_DIV),
  localparam int              CH_W    = ch_idx_width(N_CH)
) (
  input  logic              CCLK,
  input  logic              rst,
  input  logic [N_CH-1:0]   en,
  input  logic [N_CH-1:0]   mode,
  input  logic              load,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [WIDTH-1:0]  load_val,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_in,
`endif
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick
);

  logic [N_CH-1:0] ch_we;

  // Decode the load strobe into one write enable per channel. An index at
  // or above N_CH matches no channel, so such a write is simply dropped.
  always_comb begin
    ch_we = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (load && (load_ch == CH_W'(i))) begin
        ch_we[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_ch #(
      .WIDTH   (WIDTH),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk     (CCLK),
      .rst     (rst),
      .en      (en[g]),
      .mode    (clk_div_mode_e'(mode[g])),
      .div_we  (ch_we[g]),
      .div_val (load_val),
`ifdef CLKDIV_SYNC_EN
      .sync    (sync_in),
`endif
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi
// Self-checking bench for clk_div_multi (5 channels, 16-bit, reset divisor 6).
// Every cycle the reference model's expected outputs are queued when the
// inputs are driven and popped/compared one clock later; a vector table and
// hand-written sequences add fixed expected values for the corner cases.
// Exercises the CLKDIV_SYNC_EN input when that macro is defined.
module tb_clk_div_multi;

  localparam int               N_CH    = 5;
  localparam int               WIDTH   = 16;
  localparam int               CH_W    = 3;
  localparam logic [WIDTH-1:0] DEF_DIV = 16'd6;

  logic              CCLK = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   en;
  logic [N_CH-1:0]   mode;
  logic              load;
  logic [CH_W-1:0]   load_ch;
  logic [WIDTH-1:0]  load_val;
`ifdef CLKDIV_SYNC_EN
  logic              sync_in;
`endif
  logic [N_CH-1:0]   clk_out;
  logic [N_CH-1:0]   tick;

  clk_div_multi #(
    .N_CH    (N_CH),
    .WIDTH   (WIDTH),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .CCLK     (CCLK),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_ch  (load_ch),
    .load_val (load_val),
`ifdef CLKDIV_SYNC_EN
    .sync_in  (sync_in),
`endif
    .clk_out  (clk_out),
    .tick     (tick)
  );

  // 50 MHz: 20 time units per period
  always #10 CCLK = ~CCLK;

  typedef struct packed {
    logic [N_CH-1:0] clk_out;
    logic [N_CH-1:0] tick;
  } exp_t;

  typedef struct {
    logic            rst;
    logic [N_CH-1:0] en;
    logic [N_CH-1:0] mode;
    logic            load;
    logic [CH_W-1:0] load_ch;
    logic [WIDTH-1:0] load_val;
    logic [N_CH-1:0] exp_clk;
    logic [N_CH-1:0] exp_tick;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  logic [WIDTH-1:0] m_cnt [N_CH];
  logic [WIDTH-1:0] m_div [N_CH];
  logic [N_CH-1:0]  m_clk;
  logic [N_CH-1:0]  m_tick;

  int n_checks = 0;
  int n_errors = 0;

  // Reference behaviour: what every register holds after the next edge,
  // given the inputs currently driven.
  function automatic void modelStep();
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        m_cnt[i] = '0;
        m_div[i] = DEF_DIV;
      end
      m_clk  = '0;
      m_tick = '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        m_tick[i] = 1'b0;
        if (en[i]) begin
          if (m_cnt[i] >= m_div[i]) begin
            m_cnt[i] = '0;
            if (mode[i]) m_tick[i] = 1'b1;
            else         m_clk[i]  = ~m_clk[i];
          end else begin
            m_cnt[i] = m_cnt[i] + WIDTH'(1);
          end
        end
      end
`ifdef CLKDIV_SYNC_EN
      if (sync_in) begin
        for (int i = 0; i < N_CH; i++) m_cnt[i] = '0;
        m_clk  = '0;
        m_tick = '0;
      end
`endif
      if (load && (int'(load_ch) < N_CH)) m_div[load_ch] = load_val;
    end
  endfunction

  task automatic set_in(input logic r, input logic [N_CH-1:0] e, input logic [N_CH-1:0] m,
                        input logic ld, input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] v);
    rst      = r;
    en       = e;
    mode     = m;
    load     = ld;
    load_ch  = ch;
    load_val = v;
  endtask

  task automatic applyStimulus();
    modelStep();
    sb_q.push_back(exp_t'{clk_out: m_clk, tick: m_tick});
    @(posedge CCLK);
    #1;
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("[TB] FAIL %s: no expected entry queued", name);
    end else begin
      e = sb_q.pop_front();
      if (clk_out !== e.clk_out || tick !== e.tick) begin
        n_errors++;
        $display("[TB] FAIL %s: clk_out=%b tick=%b, expected clk_out=%b tick=%b",
                 name, clk_out, tick, e.clk_out, e.tick);
      end
    end
  endtask

  task automatic checkValue(input string name, input logic [N_CH-1:0] actual,
                            input logic [N_CH-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic run_cycle(input string name);
    applyStimulus();
    checkOutput(name);
  endtask

  function automatic void add_vec(input logic r, input logic [N_CH-1:0] e, input logic [N_CH-1:0] m,
                                  input logic ld, input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] v,
                                  input logic [N_CH-1:0] xc, input logic [N_CH-1:0] xt);
    vec_t t;
    t.rst = r; t.en = e; t.mode = m; t.load = ld; t.load_ch = ch; t.load_val = v;
    t.exp_clk = xc; t.exp_tick = xt;
    vecs.push_back(t);
  endfunction

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    set_in(1'b1, '0, '0, 1'b0, 3'd0, 16'd0);
`ifdef CLKDIV_SYNC_EN
    sync_in = 1'b0;
`endif

    // ---------------- reset state ----------------
    run_cycle("reset");
    run_cycle("reset");
    checkValue("reset clk_out", clk_out, 5'b00000);
    checkValue("reset tick", tick, 5'b00000);

    // ---------------- reset divisor: first tick at div+1 ----------------
    set_in(1'b0, 5'b11111, 5'b11111, 1'b0, 3'd0, 16'd0);
    repeat (6) run_cycle("default div");
    checkValue("default div no early tick", tick, 5'b00000);
    run_cycle("default div");
    checkValue("default div first tick", tick, 5'b11111);

    set_in(1'b1, '0, '0, 1'b0, 3'd0, 16'd0);
    run_cycle("reset before table");

    // ---------------- vector table ----------------
    // ch0 toggle, div=3: period 8, 4 high / 4 low, then reset mid-count
    add_vec(1'b0, 5'b00000, 5'b00000, 1'b1, 3'd0, 16'd3, 5'b00000, 5'b00000);
    for (int k = 1; k <= 12; k++)
      add_vec(1'b0, 5'b00001, 5'b00000, 1'b0, 3'd0, 16'd0,
              (((k / 4) % 2) == 1) ? 5'b00001 : 5'b00000, 5'b00000);
    add_vec(1'b0, 5'b00001, 5'b00000, 1'b0, 3'd0, 16'd0, 5'b00001, 5'b00000);
    add_vec(1'b1, 5'b00001, 5'b00000, 1'b0, 3'd0, 16'd0, 5'b00000, 5'b00000);
    add_vec(1'b0, 5'b00001, 5'b00000, 1'b0, 3'd0, 16'd0, 5'b00000, 5'b00000);
    // ch1 pulse, div=4: tick every 5th cycle, clk_out stays low
    add_vec(1'b0, 5'b00000, 5'b00000, 1'b1, 3'd1, 16'd4, 5'b00000, 5'b00000);
    for (int k = 1; k <= 10; k++)
      add_vec(1'b0, 5'b00010, 5'b00010, 1'b0, 3'd0, 16'd0,
              5'b00000, ((k % 5) == 0) ? 5'b00010 : 5'b00000);
    // div=0: load cycle still uses div=4 (count 0 -> 1), then tick held high
    add_vec(1'b0, 5'b00010, 5'b00010, 1'b1, 3'd1, 16'd0, 5'b00000, 5'b00000);
    for (int k = 0; k < 3; k++)
      add_vec(1'b0, 5'b00010, 5'b00010, 1'b0, 3'd0, 16'd0, 5'b00000, 5'b00010);
    // switch to toggle at div=0: CCLK/2, tick forced low
    add_vec(1'b0, 5'b00010, 5'b00000, 1'b0, 3'd0, 16'd0, 5'b00010, 5'b00000);
    add_vec(1'b0, 5'b00010, 5'b00000, 1'b0, 3'd0, 16'd0, 5'b00000, 5'b00000);
    add_vec(1'b0, 5'b00010, 5'b00000, 1'b0, 3'd0, 16'd0, 5'b00010, 5'b00000);

    for (int k = 0; k < vecs.size(); k++) begin
      set_in(vecs[k].rst, vecs[k].en, vecs[k].mode, vecs[k].load, vecs[k].load_ch, vecs[k].load_val);
      applyStimulus();
      checkOutput($sformatf("vec%0d model", k));
      checkValue($sformatf("vec%0d clk_out", k), clk_out, vecs[k].exp_clk);
      checkValue($sformatf("vec%0d tick", k), tick, vecs[k].exp_tick);
    end

    // ---------------- ch2: divisor shrink below count, load at wrap ----------------
    set_in(1'b1, '0, '0, 1'b0, 3'd0, 16'd0);
    run_cycle("ch2 reset");
    set_in(1'b0, 5'b00000, 5'b00000, 1'b1, 3'd2, 16'd10);
    run_cycle("ch2 load 10");
    set_in(1'b0, 5'b00100, 5'b00000, 1'b0, 3'd0, 16'd0);
    repeat (7) run_cycle("ch2 count");
    checkValue("ch2 at cnt 7", clk_out & 5'b00100, 5'b00000);
    set_in(1'b0, 5'b00100, 5'b00000, 1'b1, 3'd2, 16'd5);
    run_cycle("ch2 load 5");
    checkValue("ch2 load cycle no wrap", clk_out & 5'b00100, 5'b00000);
    set_in(1'b0, 5'b00100, 5'b00000, 1'b0, 3'd0, 16'd0);
    run_cycle("ch2 shrink wrap");
    checkValue("ch2 wrap after shrink", clk_out & 5'b00100, 5'b00100);
    set_in(1'b0, 5'b00100, 5'b00000, 1'b1, 3'd2, 16'd10);
    run_cycle("ch2 load 10 again");
    set_in(1'b0, 5'b00100, 5'b00000, 1'b0, 3'd0, 16'd0);
    repeat (9) run_cycle("ch2 count to 10");
    checkValue("ch2 before wrap", clk_out & 5'b00100, 5'b00100);
    set_in(1'b0, 5'b00100, 5'b00000, 1'b1, 3'd2, 16'd12);
    run_cycle("ch2 load at wrap");
    checkValue("ch2 wrap uses old div", clk_out & 5'b00100, 5'b00000);
    set_in(1'b0, 5'b00100, 5'b00000, 1'b0, 3'd0, 16'd0);
    repeat (12) run_cycle("ch2 new period");
    checkValue("ch2 new div no early wrap", clk_out & 5'b00100, 5'b00000);
    run_cycle("ch2 new period wrap");
    checkValue("ch2 new div wrap", clk_out & 5'b00100, 5'b00100);

    // ---------------- ch3: enable hold and resume ----------------
    set_in(1'b1, '0, '0, 1'b0, 3'd0, 16'd0);
    run_cycle("ch3 reset");
    set_in(1'b0, 5'b00000, 5'b00000, 1'b1, 3'd3, 16'd5);
    run_cycle("ch3 load 5");
    set_in(1'b0, 5'b01000, 5'b00000, 1'b0, 3'd0, 16'd0);
    repeat (6) run_cycle("ch3 first period");
    checkValue("ch3 first toggle", clk_out & 5'b01000, 5'b01000);
    repeat (2) run_cycle("ch3 to cnt 2");
    set_in(1'b0, 5'b00000, 5'b01000, 1'b0, 3'd0, 16'd0);
    repeat (20) run_cycle("ch3 disabled");
    checkValue("ch3 disabled clk_out holds", clk_out & 5'b01000, 5'b01000);
    checkValue("ch3 disabled tick low", tick, 5'b00000);
    set_in(1'b0, 5'b01000, 5'b00000, 1'b0, 3'd0, 16'd0);
    repeat (3) run_cycle("ch3 resume");
    checkValue("ch3 resume no early wrap", clk_out & 5'b01000, 5'b01000);
    run_cycle("ch3 resume wrap");
    checkValue("ch3 resume wrap", clk_out & 5'b01000, 5'b00000);

    // ---------------- out-of-range load index ----------------
    set_in(1'b1, '0, '0, 1'b0, 3'd0, 16'd0);
    run_cycle("badidx reset");
    set_in(1'b0, 5'b11111, 5'b11111, 1'b1, 3'd5, 16'd0);
    run_cycle("badidx load 5");
    set_in(1'b0, 5'b11111, 5'b11111, 1'b1, 3'd7, 16'd0);
    run_cycle("badidx load 7");
    set_in(1'b0, 5'b11111, 5'b11111, 1'b0, 3'd0, 16'd0);
    repeat (4) run_cycle("badidx run");
    checkValue("badidx no channel changed", tick, 5'b00000);
    run_cycle("badidx run");
    checkValue("badidx default wrap", tick, 5'b11111);

`ifdef CLKDIV_SYNC_EN
    // ---------------- sync_in phase alignment ----------------
    set_in(1'b1, '0, '0, 1'b0, 3'd0, 16'd0);
    run_cycle("sync reset");
    set_in(1'b0, 5'b00000, 5'b00000, 1'b1, 3'd0, 16'd3);
    run_cycle("sync load ch0");
    set_in(1'b0, 5'b00000, 5'b00000, 1'b1, 3'd1, 16'd3);
    run_cycle("sync load ch1");
    set_in(1'b0, 5'b00001, 5'b00000, 1'b0, 3'd0, 16'd0);
    repeat (2) run_cycle("sync skew");
    set_in(1'b0, 5'b11111, 5'b00000, 1'b0, 3'd0, 16'd0);
    repeat (5) run_cycle("sync skewed run");
    sync_in = 1'b1;
    run_cycle("sync pulse");
    checkValue("sync clears clk_out", clk_out, 5'b00000);
    checkValue("sync clears tick", tick, 5'b00000);
    sync_in = 1'b0;
    repeat (4) run_cycle("sync aligned");
    checkValue("sync aligned rise", clk_out & 5'b00011, 5'b00011);
    repeat (4) run_cycle("sync aligned");
    checkValue("sync aligned fall", clk_out & 5'b00011, 5'b00000);
`endif

    // ---------------- randomised run against the model ----------------
    set_in(1'b1, '0, '0, 1'b0, 3'd0, 16'd0);
    run_cycle("random reset");
    for (int c = 0; c < 10000; c++) begin
      logic [N_CH-1:0] e;
      logic [N_CH-1:0] m;
      for (int i = 0; i < N_CH; i++) e[i] = ($urandom_range(0, 7) != 0);
      m = mode;
      if ($urandom_range(0, 49) == 0) m[$urandom_range(0, N_CH - 1)] = ~m[$urandom_range(0, N_CH - 1)];
      if ($urandom_range(0, 7) == 0)
        set_in(($urandom_range(0, 499) == 0), e, m, 1'b1,
               CH_W'($urandom_range(0, 7)), WIDTH'($urandom_range(0, 15)));
      else
        set_in(($urandom_range(0, 499) == 0), e, m, 1'b0, 3'd0, 16'd0);
`ifdef CLKDIV_SYNC_EN
      sync_in = ($urandom_range(0, 199) == 0);
`endif
      run_cycle($sformatf("random cycle %0d", c));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
